mag_envelope_gate: RTL and testbench

- Consumes the 32-bit magnitude/phase AXI stream produced by the complex-to-magnitude/phase CORDIC stage inside the envelope NoC block.
- Smooths the magnitude with a single-pole leaky integrator (programmable shift).
- Drives a hysteretic, debounced signal-present gate.
- Emits {smoothed, raw} magnitude per sample plus gate status, for squelch/burst detection.

---
 rtl/mag_envelope_gate.sv | 139 +++++++++++++
 tb/tb_mag_envelope_gate.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_envelope_gate.sv
// Envelope smoother and hysteretic signal-present gate for CORDIC mag/phase beats.
// Ports: aclk/aresetn, clear, config (alpha_shift, thresh_hi/lo, hold_len),
//   AXI-S in (i_t*), AXI-S out (o_t*: {avg, raw}, tuser=gate), gate + strobes.
//   Optional macro PEAK_HOLD_EN adds peak (out 16) and peak_clr (in 1).
module mag_envelope_gate #(
    parameter int FRAC_BITS = 8,
    parameter int CNT_W     = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic [3:0]       alpha_shift,
    input  logic [15:0]      thresh_hi,
    input  logic [15:0]      thresh_lo,
    input  logic [CNT_W-1:0] hold_len,
    input  logic [31:0]      i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [31:0]      o_tdata,
    output logic             o_tuser,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
`ifdef PEAK_HOLD_EN
    output logic [15:0]      peak,
    input  logic             peak_clr,
`endif
    output logic             gate,
    output logic             gate_open_stb,
    output logic             gate_close_stb
);

    localparam int ACC_W = 16 + FRAC_BITS;

    localparam logic [0:0] ST_CLOSED = 1'b0;
    localparam logic [0:0] ST_OPEN   = 1'b1;

    logic [ACC_W-1:0] acc;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    logic                    accept;
    logic [ACC_W-1:0]        acc_base;
    logic [0:0]              st_base;
    logic [CNT_W-1:0]        cnt_base;
    logic [ACC_W-1:0]        mag_ext;
    logic signed [ACC_W:0]   diff;
    logic signed [ACC_W:0]   step;
    logic [ACC_W-1:0]        acc_nxt;
    logic [15:0]             avg;
    logic [CNT_W-1:0]        hold_eff;
    logic                    hit;
    logic [CNT_W-1:0]        cnt_upd;
    logic                    flip;
    logic [0:0]              st_nxt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    unused_phase;

    assign unused_phase = ^i_tdata[31:16];
    assign i_tready     = ~o_tvalid | o_tready;
    assign accept       = i_tvalid & i_tready;
    assign gate         = (state == ST_OPEN);

    always_comb begin
        // A coincident clear makes this sample the first one after clearing.
        acc_base = clear ? '0 : acc;
        st_base  = clear ? ST_CLOSED : state;
        cnt_base = clear ? '0 : cnt;
        mag_ext  = {i_tdata[15:0], {FRAC_BITS{1'b0}}};
        diff     = $signed({1'b0, mag_ext}) - $signed({1'b0, acc_base});
        step     = diff >>> alpha_shift;
        acc_nxt  = ACC_W'($signed({1'b0, acc_base}) + step);
        avg      = acc_nxt[ACC_W-1:FRAC_BITS];
        hold_eff = (hold_len == '0) ? CNT_W'(1) : hold_len;
        hit      = (st_base == ST_OPEN) ? (avg < thresh_lo)
                                        : (avg >= thresh_hi);
        cnt_upd  = '0;
        if (hit)
            cnt_upd = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
        flip     = (cnt_upd >= hold_eff);
        st_nxt   = flip ? ~st_base : st_base;
        cnt_nxt  = flip ? '0 : cnt_upd;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc            <= '0;
            state          <= ST_CLOSED;
            cnt            <= '0;
            o_tvalid       <= 1'b0;
            o_tdata        <= '0;
            o_tuser        <= 1'b0;
            o_tlast        <= 1'b0;
            gate_open_stb  <= 1'b0;
            gate_close_stb <= 1'b0;
        end else begin
            gate_open_stb  <= 1'b0;
            gate_close_stb <= 1'b0;
            if (accept) begin
                acc            <= acc_nxt;
                state          <= st_nxt;
                cnt            <= cnt_nxt;
                o_tvalid       <= 1'b1;
                o_tdata        <= {avg, i_tdata[15:0]};
                o_tuser        <= (st_nxt == ST_OPEN);
                o_tlast        <= i_tlast;
                gate_open_stb  <= flip & (st_base == ST_CLOSED);
                gate_close_stb <= flip & (st_base == ST_OPEN);
            end else begin
                if (clear) begin
                    acc   <= '0;
                    state <= ST_CLOSED;
                    cnt   <= '0;
                end
                if (o_tready)
                    o_tvalid <= 1'b0;
            end
        end
    end

`ifdef PEAK_HOLD_EN
    logic        peak_rst;
    logic [15:0] peak_base;

    assign peak_rst  = clear | peak_clr;
    assign peak_base = peak_rst ? 16'd0 : peak;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            peak <= '0;
        else if (accept)
            peak <= (avg > peak_base) ? avg : peak_base;
        else if (peak_rst)
            peak <= '0;
    end
`endif

endmodule

// File: tb/tb_mag_envelope_gate.sv
// Scoreboard bench for mag_envelope_gate: directed plan cases plus random traffic.
// A reference model predicts each beat at accept; a monitor checks on consume.
module tb_mag_envelope_gate;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  alpha_shift = '0;
    logic [15:0] thresh_hi = 16'd1000;
    logic [15:0] thresh_lo = 16'd500;
    logic [15:0] hold_len = 16'd1;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tuser;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [15:0] peak;
    logic        peak_clr = 1'b0;
    logic        gate;
    logic        gate_open_stb;
    logic        gate_close_stb;

    mag_envelope_gate dut (
        .aclk(aclk), .aresetn(aresetn), .clear(clear),
        .alpha_shift(alpha_shift), .thresh_hi(thresh_hi),
        .thresh_lo(thresh_lo), .hold_len(hold_len),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tuser(o_tuser),
        .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
`ifdef PEAK_HOLD_EN
        .peak(peak), .peak_clr(peak_clr),
`endif
        .gate(gate), .gate_open_stb(gate_open_stb),
        .gate_close_stb(gate_close_stb)
    );

`ifndef PEAK_HOLD_EN
    assign peak = 16'd0;
`endif

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t  exp_q[$];
    int     obs_avg[$];
    int     obs_user[$];
    int     errors = 0;
    int     checks = 0;
    bit     mon_en = 0;
    int     open_cnt = 0;
    int     close_cnt = 0;

    // reference model state
    longint m_acc = 0;
    bit     m_open = 0;
    int     m_cnt = 0;
    int     m_peak = 0;
    bit     e_open = 0;
    bit     e_close = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (mon_en) begin
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("tdata", o_tdata, e.d);
                    chk("tuser", o_tuser, e.u);
                    chk("tlast", o_tlast, e.l);
                    obs_avg.push_back(int'(o_tdata[31:16]));
                    obs_user.push_back(int'(o_tuser));
                end
            end
            chk("gate", gate, m_open);
            chk("open_stb", gate_open_stb, e_open);
            chk("close_stb", gate_close_stb, e_close);
`ifdef PEAK_HOLD_EN
            chk("peak", peak, m_peak);
`endif
            if (gate_open_stb) open_cnt++;
            if (gate_close_stb) close_cnt++;

            e_open = 0;
            e_close = 0;
            if (clear) begin
                m_acc = 0;
                m_open = 0;
                m_cnt = 0;
                m_peak = 0;
            end
            if (peak_clr) m_peak = 0;
            if (i_tvalid && i_tready) begin
                longint tgt;
                int     avg;
                int     hold;
                bit     cond;
                beat_t  b;
                tgt   = longint'(i_tdata[15:0]) * 256;
                m_acc = m_acc + ((tgt - m_acc) >>> alpha_shift);
                avg   = int'(m_acc / 256);
                hold  = (hold_len == 0) ? 1 : int'(hold_len);
                cond  = m_open ? (avg < thresh_lo) : (avg >= thresh_hi);
                m_cnt = cond ? ((m_cnt < 65535) ? m_cnt + 1 : 65535) : 0;
                if (m_cnt >= hold) begin
                    m_open = !m_open;
                    m_cnt = 0;
                    if (m_open) e_open = 1;
                    else e_close = 1;
                end
                if (avg > m_peak) m_peak = avg;
                b.d = {avg[15:0], i_tdata[15:0]};
                b.u = m_open;
                b.l = i_tlast;
                exp_q.push_back(b);
            end
        end
    end

    task automatic send(input logic [15:0] mag, input logic last,
                        input logic clr, input logic pclr);
        int   n;
        logic ok;
        n = 0;
        i_tvalid = 1'b1;
        i_tdata  = {16'($urandom), mag};
        i_tlast  = last;
        clear    = clr;
        peak_clr = pclr;
        do begin
            @(negedge aclk);
            ok = i_tready;
            @(posedge aclk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) chk("send_timeout", 0, 1);
        i_tvalid = 1'b0;
        clear    = 1'b0;
        peak_clr = 1'b0;
    endtask

    task automatic drain();
        o_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int c0;
        int o0;
        #12;
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tdata", o_tdata, 0);
        chk("rst_gate", gate, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        mon_en = 1;

        // basic open/close, k=0
        obs_avg.delete(); obs_user.delete();
        o0 = open_cnt; c0 = close_cnt;
        send(16'd0, 0, 0, 0);
        send(16'd1200, 0, 0, 0);
        send(16'd400, 1, 0, 0);
        drain();
        chk("t1_avg0", obs_avg[0], 0);
        chk("t1_avg1", obs_avg[1], 1200);
        chk("t1_avg2", obs_avg[2], 400);
        chk("t1_user0", obs_user[0], 0);
        chk("t1_user1", obs_user[1], 1);
        chk("t1_user2", obs_user[2], 0);
        chk("t1_opens", open_cnt - o0, 1);
        chk("t1_closes", close_cnt - c0, 1);

        // step response k=2
        clear_pulse();
        alpha_shift = 4'd2;
        thresh_hi = 16'hFFFF;
        obs_avg.delete();
        repeat (4) send(16'd4096, 0, 0, 0);
        drain();
        chk("step0", obs_avg[0], 1024);
        chk("step1", obs_avg[1], 1792);
        chk("step2", obs_avg[2], 2368);
        chk("step3", obs_avg[3], 2800);

        // debounce hold_len=3
        clear_pulse();
        alpha_shift = 4'd0;
        thresh_hi = 16'd100;
        thresh_lo = 16'd10;
        hold_len = 16'd3;
        obs_user.delete();
        send(16'd200, 0, 0, 0);
        send(16'd200, 0, 0, 0);
        send(16'd50, 0, 0, 0);
        send(16'd200, 0, 0, 0);
        send(16'd200, 0, 0, 0);
        send(16'd200, 1, 0, 0);
        drain();
        chk("deb_user4", obs_user[4], 0);
        chk("deb_user5", obs_user[5], 1);
        chk("deb_cnt", obs_user.size(), 6);

        // backpressure over a 16-beat packet
        hold_len = 16'd1;
        thresh_hi = 16'd1000;
        thresh_lo = 16'd500;
        o_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(16'($urandom_range(0, 3000)), (i == 15), 0, 0);
            end
            begin
                @(posedge aclk);
                repeat (5) begin
                    @(negedge aclk);
                    chk("bp_itready", i_tready, 0);
                    chk("bp_otvalid", o_tvalid, 1);
                end
                @(posedge aclk);
                #1;
                o_tready = 1'b1;
            end
        join
        drain();
        chk("bp_drained", exp_q.size(), 0);

        // clear coincident with accept while open
        alpha_shift = 4'd0;
        repeat (3) send(16'd3000, 0, 0, 0);
        drain();
        chk("cl_open", gate, 1);
        c0 = close_cnt;
        obs_avg.delete(); obs_user.delete();
        alpha_shift = 4'd1;
        send(16'd800, 1, 1, 0);
        drain();
        chk("cl_avg", obs_avg[0], 400);
        chk("cl_user", obs_user[0], 0);
        chk("cl_gate", gate, 0);
        chk("cl_nostb", close_cnt - c0, 0);

`ifdef PEAK_HOLD_EN
        clear_pulse();
        alpha_shift = 4'd0;
        send(16'd10, 0, 0, 0);
        send(16'd900, 0, 0, 0);
        send(16'd300, 0, 0, 0);
        drain();
        chk("peak_max", peak, 900);
        send(16'd300, 0, 0, 1);
        drain();
        chk("peak_clr", peak, 300);
`endif

        // random traffic
        thresh_hi = 16'd2000;
        thresh_lo = 16'd1000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic a;
            @(negedge aclk);
            a = i_tvalid & i_tready;
            @(posedge aclk);
            #1;
            if (!i_tvalid || a) begin
                i_tvalid = ($urandom_range(0, 3) != 0);
                i_tdata  = $urandom;
                if ($urandom_range(0, 7) != 0)
                    i_tdata[15:0] = 16'($urandom_range(0, 4000));
                i_tlast  = ($urandom_range(0, 7) == 0);
            end
            o_tready    = ($urandom_range(0, 3) != 0);
            clear       = ($urandom_range(0, 63) == 0);
            peak_clr    = ($urandom_range(0, 31) == 0);
            alpha_shift = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0)
                hold_len = 16'($urandom_range(0, 3));
        end
        i_tvalid = 1'b0;
        clear = 1'b0;
        peak_clr = 1'b0;
        drain();
        chk("rnd_drained", exp_q.size(), 0);

        // async reset mid-cycle with a beat held
        send(16'd1500, 1, 0, 0);
        o_tready = 1'b0;
        #3;
        mon_en = 0;
        aresetn = 1'b0;
        #1;
        chk("ar_tvalid", o_tvalid, 0);
        chk("ar_tdata", o_tdata, 0);
        chk("ar_tuser", o_tuser, 0);
        chk("ar_tlast", o_tlast, 0);
        chk("ar_gate", gate, 0);
        chk("ar_ostb", gate_open_stb, 0);
        chk("ar_cstb", gate_close_stb, 0);
`ifdef PEAK_HOLD_EN
        chk("ar_peak", peak, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
